// File: rtl/psum_drain_pkg.sv
// Shared definitions for the PE-row drain controller: state encoding,
// default widths and the Q9.14 fixed-point constants of the PE datapath.
package psum_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FLUSH = 2'd3
    } drain_state_t;

    localparam int DW_DEF    = 24;
    localparam int AXI_W_DEF = 32;

    // Q9.14: 1 sign bit, 9 integer bits, 14 fractional bits
    localparam int          Q_FRAC = 14;
    localparam logic [23:0] Q_MAX  = 24'h7FFFFF;
    localparam logic [23:0] Q_MIN  = 24'h800000;

endpackage

// File: rtl/psum_drain_fifo.sv
// First-word-fall-through FIFO buffering drained words (data plus tlast tag)
// ahead of the AXI4-Stream output. rd_data is valid whenever empty is low.
module psum_drain_fifo
    import psum_drain_pkg::*;
#(
    parameter int W     = DW_DEF + 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    // A write into a full FIFO is dropped even if a read frees a slot that cycle
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array write
    // NOTE: the storage array is deliberately not reset; count gates every read,
    // so stale entries are never observed and the array can map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drain controller for one output-stationary PE row. On start it snapshots
// every PE psum into the ejection chain, shifts the chain out one word per
// enabled cycle into a small FWFT FIFO, and emits the words on AXI4-Stream.
// Optional build macro OUTPUT_RELU_EN clamps negative words to zero before
// they enter the FIFO.
module psum_drain_ctrl
    import psum_drain_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int NUM_PE     = 16,
    parameter int AXI_W      = AXI_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear_after,
    output logic             busy,
    output logic             done,
    output logic             pe_eject_ctrl,
    output logic             pe_en_out,
    output logic             pe_clear_psum,
    input  logic [DW-1:0]    chain_in,
    output logic [AXI_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    localparam int CW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    drain_state_t state;
    drain_state_t state_nxt;
    logic [CW-1:0] shift_cnt;
    logic          clear_lat;

    logic                        fifo_wr;
    logic                        fifo_rd;
    logic                        wr_last;
    logic [DW-1:0]               wr_word;
    logic [DW:0]                 rd_data;
    logic [DW-1:0]               rd_word;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch clear_after on an accepted start; count words shifted out of the chain
    always_ff @(posedge clk) begin
        if (!rst) begin
            clear_lat <= 1'b0;
            shift_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                clear_lat <= clear_after;
            end
            if (state == LOAD) begin
                shift_cnt <= '0;
            end else if (fifo_wr) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    // Next-state and PE control decode
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        pe_eject_ctrl = 1'b0;
        pe_en_out     = 1'b0;
        pe_clear_psum = 1'b0;
        fifo_wr       = 1'b0;
        wr_last       = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                // Same edge captures the pre-clear psum into output_reg
                pe_en_out     = 1'b1;
                pe_clear_psum = clear_lat;
                state_nxt     = SHIFT;
            end
            SHIFT: begin
                pe_eject_ctrl = 1'b1;
                pe_en_out     = !fifo_full;
                fifo_wr       = !fifo_full;
                wr_last       = (shift_cnt == CW'(NUM_PE - 1));
                if (fifo_wr && wr_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (fifo_count == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && !done;

`ifdef OUTPUT_RELU_EN
    assign wr_word = chain_in[DW-1] ? '0 : chain_in;
`else
    assign wr_word = chain_in;
`endif

    assign fifo_rd = m_axis_tvalid && m_axis_tready;

    psum_drain_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data ({wr_last, wr_word}),
        .rd_en   (fifo_rd),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Stream side: head of the FIFO, sign-extended; zeroed while nothing is buffered
    assign rd_word       = rd_data[DW-1:0];
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = !fifo_empty && rd_data[DW];
    assign m_axis_tdata  = fifo_empty ? '0 : {{(AXI_W-DW){rd_word[DW-1]}}, rd_word};

endmodule
